// File: rtl/vga_gray_window_driver.sv
// vga_gray_window_driver
//
// VGA timing generator and pixel formatter for a 1024x768@70Hz display,
// running on a 75 MHz pixel clock. Grayscale pixels are fetched from an
// upstream show-ahead frame buffer. They are shown as a 640x480 window
// centred in the active area. The block drives the VGA sync lines and an
// ADV7123 video DAC.
//
// Optional feature macro: VGA_TEST_PATTERN_EN
//   When defined, the frame buffer is not read (rden held at 0). Inside the
//   window the pixel value becomes (h_cnt - IMG_X0) mod 256, which draws a
//   horizontal gray ramp. Timing, blank_n, clr and latency do not change.
//
// Ports:
//   i_clk                 75 MHz pixel clock
//   i_rst_n               asynchronous active-low reset
//   o_display_image_rden  pixel read/advance strobe to the frame buffer
//   o_display_image_clr   frame-start clear of the upstream read pointer
//   i_display_image_data  8-bit grayscale pixel, show-ahead
//   o_vga_r/g/b           RGB565 taken from pixel[7:3] / [7:2] / [7:3]
//   o_vga_rgb             pixel[2:0] for the DAC LSBs
//   o_vga_hsy, o_vga_vsy  horizontal / vertical sync, active low
//   o_adv7123_blank_n     high only inside the image window
//   o_adv7123_sync_n      composite sync, tied 0
//
// Frame buffer handshake:
//   The buffer presents the current pixel on i_display_image_data before it
//   is requested. In any cycle with rden=1 that pixel is consumed, and the
//   buffer advances its pointer on the same rising clock edge. rden is
//   combinational from the counters. Every output is registered, so all
//   outputs appear one cycle later and stay aligned with one another.
//   A clr pulse resets the buffer pointer to the first pixel of the frame.

module vga_gray_window_driver #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 144,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int IMG_X0   = 192,
    parameter int IMG_Y0   = 144
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_display_image_rden,
    output logic       o_display_image_clr,
    input  logic [7:0] i_display_image_data,
    output logic [4:0] o_vga_r,
    output logic [5:0] o_vga_g,
    output logic [4:0] o_vga_b,
    output logic [2:0] o_vga_rgb,
    output logic       o_vga_hsy,
    output logic       o_vga_vsy,
    output logic       o_adv7123_blank_n,
    output logic       o_adv7123_sync_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] X_FIRST      = HW'(IMG_X0);
    localparam logic [HW-1:0] X_LAST       = HW'(IMG_X0 + IMG_W - 1);

    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] Y_FIRST      = VW'(IMG_Y0);
    localparam logic [VW-1:0] Y_LAST       = VW'(IMG_Y0 + IMG_H - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          win;
    logic          h_sync;
    logic          v_sync;
    logic          frame_start;
    logic [7:0]    pix;

    // Raster counters: h_cnt wraps every line, v_cnt steps on each h wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Decode of the current counter state. Everything below is registered
    // from these signals in the same cycle, so the outputs stay aligned.
    always_comb begin
        win         = (h_cnt >= X_FIRST) && (h_cnt <= X_LAST) &&
                      (v_cnt >= Y_FIRST) && (v_cnt <= Y_LAST);
        h_sync      = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
        v_sync      = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);
        frame_start = (h_cnt == '0) && (v_cnt == V_SYNC_FIRST);
    end

`ifdef VGA_TEST_PATTERN_EN
    // Ramp value is the column offset inside the window, wrapped to 8 bits.
    assign pix                  = 8'(16'(h_cnt) - 16'(IMG_X0));
    assign o_display_image_rden = 1'b0;
`else
    assign pix                  = i_display_image_data;
    assign o_display_image_rden = win;
`endif

    // clr is held high during reset so the upstream pointer starts at the
    // first pixel. After reset it pulses once per frame, in step with the
    // falling edge of vsync.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vga_r             <= '0;
            o_vga_g             <= '0;
            o_vga_b             <= '0;
            o_vga_rgb           <= '0;
            o_vga_hsy           <= 1'b1;
            o_vga_vsy           <= 1'b1;
            o_adv7123_blank_n   <= 1'b0;
            o_display_image_clr <= 1'b1;
        end else begin
            o_vga_r             <= win ? pix[7:3] : 5'd0;
            o_vga_g             <= win ? pix[7:2] : 6'd0;
            o_vga_b             <= win ? pix[7:3] : 5'd0;
            o_vga_rgb           <= win ? pix[2:0] : 3'd0;
            o_vga_hsy           <= ~h_sync;
            o_vga_vsy           <= ~v_sync;
            o_adv7123_blank_n   <= win;
            o_display_image_clr <= frame_start;
        end
    end

    assign o_adv7123_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_gray_window_driver.sv
`timescale 1ns/1ps
// Bench for vga_gray_window_driver.
// Instance d_* uses the real 1024x768 timing. It covers reset values and
// line timing over the first few lines.
// Instance s_* uses a shrunken raster so that whole frames fit in a short
// run: H 40/4/6/6 (56 total), V 20/2/3/3 (28 total), 16x8 window at (12,6).
// It covers frame timing, clr, window/rden, the data path, the round trip
// and a reset asserted mid-frame.
module tb_vga_gray_window_driver;
    localparam int SH_TOT  = 56;
    localparam int SV_TOT  = 28;
    localparam int S_FRAME = SH_TOT * SV_TOT;          // 1568
    localparam int S_PIX   = 16 * 8;                   // 128
    // Run ends at frame 3, line 6, column 15: inside the window.
    localparam int N_RUN   = 2 * S_FRAME + 6 * SH_TOT + 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #6.667 clk = ~clk;

    logic       d_rden, d_clr, d_hsy, d_vsy, d_blank, d_sync;
    logic [7:0] d_data;
    logic [4:0] d_r, d_b;
    logic [5:0] d_g;
    logic [2:0] d_rgb;

    logic       s_rden, s_clr, s_hsy, s_vsy, s_blank, s_sync;
    logic [7:0] s_data;
    logic [4:0] s_r, s_b;
    logic [5:0] s_g;
    logic [2:0] s_rgb;

    vga_gray_window_driver dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_display_image_rden(d_rden), .o_display_image_clr(d_clr),
        .i_display_image_data(d_data),
        .o_vga_r(d_r), .o_vga_g(d_g), .o_vga_b(d_b), .o_vga_rgb(d_rgb),
        .o_vga_hsy(d_hsy), .o_vga_vsy(d_vsy),
        .o_adv7123_blank_n(d_blank), .o_adv7123_sync_n(d_sync)
    );

    vga_gray_window_driver #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(3), .V_BP(3),
        .IMG_W(16), .IMG_H(8), .IMG_X0(12), .IMG_Y0(6)
    ) dut_s (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_display_image_rden(s_rden), .o_display_image_clr(s_clr),
        .i_display_image_data(s_data),
        .o_vga_r(s_r), .o_vga_g(s_g), .o_vga_b(s_b), .o_vga_rgb(s_rgb),
        .o_vga_hsy(s_hsy), .o_vga_vsy(s_vsy),
        .o_adv7123_blank_n(s_blank), .o_adv7123_sync_n(s_sync)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Source image in raster order; pixel 0 is the 0xB5 data-path vector.
    function automatic logic [7:0] img(input int i);
        if (i == 0) return 8'hB5;
        return 8'(i * 73 + 11);
    endfunction

    task automatic fill_exp();
        for (int i = 0; i < S_PIX; i++) exp_q.push_back(img(i));
    endtask

    initial begin
        int ptr, h, v, rden_err, rden_cnt, lag_err, outside_err, pops;
        int clr_cnt, clr_err, s_hf1, s_hr1, s_vf1, s_vr1, s_vf2;
        int d_hf1, d_hr1, d_hf2, d_vsy_low, d_clr_cnt, d_act_cnt;
        logic exp_rden, prev_rden, prev_clr, prev_s_hsy, prev_s_vsy, prev_d_hsy;
        logic first_blank;
        logic [7:0] e;

        ptr = 0; rden_err = 0; rden_cnt = 0; lag_err = 0; outside_err = 0; pops = 0;
        clr_cnt = 0; clr_err = 0; s_hf1 = -1; s_hr1 = -1; s_vf1 = -1; s_vr1 = -1; s_vf2 = -1;
        d_hf1 = -1; d_hr1 = -1; d_hf2 = -1; d_vsy_low = 0; d_clr_cnt = 0; d_act_cnt = 0;
        first_blank = 1'b1;
        d_data = 8'h00;
        s_data = img(0);

        // Reset held for 1 us.
        rst_n = 1'b0;
        #1000;
        @(negedge clk);
        check("rst_d_hsy", d_hsy, 1);
        check("rst_d_vsy", d_vsy, 1);
        check("rst_d_blank", d_blank, 0);
        check("rst_d_rden", d_rden, 0);
        check("rst_d_clr", d_clr, 1);
        check("rst_d_colour", {d_r, d_g, d_b, d_rgb}, 0);
        check("rst_d_sync_n", d_sync, 0);
        check("rst_s_hsy", s_hsy, 1);
        check("rst_s_vsy", s_vsy, 1);
        check("rst_s_blank", s_blank, 0);
        check("rst_s_rden", s_rden, 0);
        check("rst_s_clr", s_clr, 1);
        check("rst_s_colour", {s_r, s_g, s_b, s_rgb}, 0);

        fill_exp();
        prev_rden = 1'b0; prev_clr = 1'b1;
        prev_s_hsy = 1'b1; prev_s_vsy = 1'b1; prev_d_hsy = 1'b1;
        rst_n = 1'b1;

        // Iteration n samples the state after n rising edges since release.
        for (int n = 1; n <= N_RUN; n++) begin
            @(posedge clk);
            // Show-ahead buffer model: clr rewinds the pointer, rden advances it.
            if (prev_clr) ptr = 0;
            else if (prev_rden) ptr++;
            @(negedge clk);
            s_data = img(ptr);

            h = n % SH_TOT;
            v = (n / SH_TOT) % SV_TOT;
            exp_rden = (h >= 12 && h <= 27 && v >= 6 && v <= 13);
            if (s_rden !== exp_rden) rden_err++;
            if (n < S_FRAME && s_rden) rden_cnt++;
            if (s_blank !== prev_rden) lag_err++;

            if (s_blank) begin
                if (first_blank) begin
                    check("dp_r", s_r, 5'h16);
                    check("dp_g", s_g, 6'h2D);
                    check("dp_b", s_b, 5'h16);
                    check("dp_rgb", s_rgb, 3'h5);
                    first_blank = 1'b0;
                end
                pops++;
                if (exp_q.size() == 0) begin
                    check("rt_queue_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rt_r_rgb", {s_r, s_rgb}, e);
                    check("rt_g_rgb", {s_g, s_rgb[1:0]}, e);
                    check("rt_b_rgb", {s_b, s_rgb}, e);
                end
            end else if ({s_r, s_g, s_b, s_rgb} != 0) begin
                outside_err++;
            end

            if (s_clr) begin
                clr_cnt++;
                if (!(prev_s_vsy && !s_vsy)) clr_err++;
                check("rt_frame_drained", exp_q.size(), 0);
                exp_q.delete();
                fill_exp();
            end

            if (prev_s_hsy && !s_hsy && s_hf1 < 0) s_hf1 = n;
            if (!prev_s_hsy && s_hsy && s_hr1 < 0) s_hr1 = n;
            if (prev_s_vsy && !s_vsy) begin
                if (s_vf1 < 0) s_vf1 = n;
                else if (s_vf2 < 0) s_vf2 = n;
            end
            if (!prev_s_vsy && s_vsy && s_vr1 < 0) s_vr1 = n;

            if (prev_d_hsy && !d_hsy) begin
                if (d_hf1 < 0) d_hf1 = n;
                else if (d_hf2 < 0) d_hf2 = n;
            end
            if (!prev_d_hsy && d_hsy && d_hr1 < 0) d_hr1 = n;
            if (!d_vsy) d_vsy_low++;
            if (d_clr) d_clr_cnt++;
            if (d_rden || d_blank) d_act_cnt++;

            prev_rden = s_rden;
            prev_clr = s_clr;
            prev_s_hsy = s_hsy;
            prev_s_vsy = s_vsy;
            prev_d_hsy = d_hsy;
        end

        // Full-size line timing.
        check("d_hsy_first_fall", d_hf1, 1049);
        check("d_hsy_first_rise", d_hr1, 1049 + 136);
        check("d_hsy_second_fall", d_hf2, 1049 + 1328);
        check("d_vsy_low_cycles", d_vsy_low, 0);
        check("d_clr_pulses", d_clr_cnt, 0);
        check("d_rden_blank_active", d_act_cnt, 0);
        check("d_sync_n", d_sync, 0);

        // Shrunken raster: line, frame, window and clr timing.
        check("s_hsy_first_fall", s_hf1, 45);
        check("s_hsy_first_rise", s_hr1, 51);
        check("s_vsy_first_fall", s_vf1, 22 * SH_TOT + 1);
        check("s_vsy_first_rise", s_vr1, 25 * SH_TOT + 1);
        check("s_vsy_second_fall", s_vf2, 22 * SH_TOT + 1 + S_FRAME);
        check("s_rden_pattern_err", rden_err, 0);
        check("s_rden_frame_total", rden_cnt, S_PIX);
        check("s_blank_lag_err", lag_err, 0);
        check("s_outside_colour_err", outside_err, 0);
        check("s_clr_pulses", clr_cnt, 2);
        check("s_clr_align_err", clr_err, 0);
        check("s_pixels_shown", pops, 2 * S_PIX + 3);
        check("s_sync_n", s_sync, 0);

        // Reset asserted while the window is active takes effect at once.
        check("mid_pre_blank", s_blank, 1);
        rst_n = 1'b0;
        #1;
        check("mid_s_blank", s_blank, 0);
        check("mid_s_rden", s_rden, 0);
        check("mid_s_clr", s_clr, 1);
        check("mid_s_colour", {s_r, s_g, s_b, s_rgb}, 0);
        check("mid_s_hsy_vsy", {s_hsy, s_vsy}, 2'b11);
        check("mid_d_clr", d_clr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
